// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - two-port arbiter/sequencer for the single-port data SRAM
// Grants core or debug access, registers active-low SRAM controls, and routes read data back by tag.
module dmem_arbiter #(
  parameter int AW       = 7,
  parameter int DW       = 32,
  parameter int ARB_MODE = 0
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          core_req,
  input  logic          core_we,
  input  logic [AW-1:0] core_addr,
  input  logic [DW-1:0] core_wdata,
  output logic          core_gnt,
  output logic          core_rvalid,
  output logic [DW-1:0] core_rdata,
  input  logic          dbg_req,
  input  logic          dbg_we,
  input  logic [AW-1:0] dbg_addr,
  input  logic [DW-1:0] dbg_wdata,
  output logic          dbg_gnt,
  output logic          dbg_rvalid,
  output logic [DW-1:0] dbg_rdata,
  output logic          CEN,
  output logic          WEN,
  output logic          OEN,
  output logic [AW-1:0] A,
  output logic [DW-1:0] Data2Mem,
  input  logic [DW-1:0] ReadDataMem
);

  localparam logic PORT_CORE = 1'b0;
  localparam logic PORT_DBG  = 1'b1;
  localparam logic FIXED_PRI = (ARB_MODE != 0);

  logic          lg_q, lg_d;
  logic          cen_q, cen_d;
  logic          wen_q, wen_d;
  logic          oen_q, oen_d;
  logic [AW-1:0] a_q, a_d;
  logic [DW-1:0] d2m_q, d2m_d;
  logic          tag1_vld_q, tag1_vld_d;
  logic          tag1_port_q, tag1_port_d;
  logic          tag2_vld_q, tag2_vld_d;
  logic          tag2_port_q, tag2_port_d;

  // Core wins contention when fixed priority is selected or when debug was granted last.
  assign core_gnt = core_req & (~dbg_req | FIXED_PRI | (lg_q == PORT_DBG));
  assign dbg_gnt  = dbg_req & ~core_gnt;

  always_comb begin
    lg_d        = lg_q;
    cen_d       = 1'b1;
    wen_d       = 1'b1;
    oen_d       = 1'b1;
    a_d         = a_q;
    d2m_d       = d2m_q;
    tag1_vld_d  = 1'b0;
    tag1_port_d = PORT_CORE;
    if (core_gnt) begin
      lg_d        = PORT_CORE;
      cen_d       = 1'b0;
      wen_d       = ~core_we;
      oen_d       = core_we;
      a_d         = core_addr;
      d2m_d       = core_wdata;
      tag1_vld_d  = ~core_we;
      tag1_port_d = PORT_CORE;
    end else if (dbg_gnt) begin
      lg_d        = PORT_DBG;
      cen_d       = 1'b0;
      wen_d       = ~dbg_we;
      oen_d       = dbg_we;
      a_d         = dbg_addr;
      d2m_d       = dbg_wdata;
      tag1_vld_d  = ~dbg_we;
      tag1_port_d = PORT_DBG;
    end
    // Stage 2 lines up with the cycle the SRAM drives the read data.
    tag2_vld_d  = tag1_vld_q;
    tag2_port_d = tag1_port_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lg_q        <= PORT_DBG;
      cen_q       <= 1'b1;
      wen_q       <= 1'b1;
      oen_q       <= 1'b1;
      a_q         <= '0;
      d2m_q       <= '0;
      tag1_vld_q  <= 1'b0;
      tag1_port_q <= PORT_CORE;
      tag2_vld_q  <= 1'b0;
      tag2_port_q <= PORT_CORE;
    end else begin
      lg_q        <= lg_d;
      cen_q       <= cen_d;
      wen_q       <= wen_d;
      oen_q       <= oen_d;
      a_q         <= a_d;
      d2m_q       <= d2m_d;
      tag1_vld_q  <= tag1_vld_d;
      tag1_port_q <= tag1_port_d;
      tag2_vld_q  <= tag2_vld_d;
      tag2_port_q <= tag2_port_d;
    end
  end

  assign CEN         = cen_q;
  assign WEN         = wen_q;
  assign OEN         = oen_q;
  assign A           = a_q;
  assign Data2Mem    = d2m_q;
  assign core_rvalid = tag2_vld_q & (tag2_port_q == PORT_CORE);
  assign dbg_rvalid  = tag2_vld_q & (tag2_port_q == PORT_DBG);
  assign core_rdata  = ReadDataMem;
  assign dbg_rdata   = ReadDataMem;

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - self-checking bench for dmem_arbiter
// Round-robin instance is fully checked; a fixed-priority instance shares the inputs for grant checks.
module tb_dmem_arbiter;
  localparam int AW = 7;
  localparam int DW = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic core_req, core_we, dbg_req, dbg_we;
  logic [AW-1:0] core_addr, dbg_addr;
  logic [DW-1:0] core_wdata, dbg_wdata;
  logic core_gnt, core_rvalid, dbg_gnt, dbg_rvalid;
  logic [DW-1:0] core_rdata, dbg_rdata;
  logic cen, wen, oen;
  logic [AW-1:0] a;
  logic [DW-1:0] d2m, rdm;
  logic core_gnt1, core_rvalid1, dbg_gnt1, dbg_rvalid1, cen1, wen1, oen1;
  logic [AW-1:0] a1;
  logic [DW-1:0] core_rdata1, dbg_rdata1, d2m1, rdm1;
  logic [DW-1:0] sram [128];
  logic mem_clr = 1'b1;
  int total = 0;
  int bad = 0;

  assign rdm1 = '0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < 128; i++) sram[i] <= '0;
    end else if (!cen) begin
      if (!wen) sram[a] <= d2m;
      else if (!oen) rdm <= sram[a];
    end
  end

  dmem_arbiter #(.AW(AW), .DW(DW), .ARB_MODE(0)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .core_req(core_req), .core_we(core_we), .core_addr(core_addr), .core_wdata(core_wdata),
    .core_gnt(core_gnt), .core_rvalid(core_rvalid), .core_rdata(core_rdata),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
    .dbg_gnt(dbg_gnt), .dbg_rvalid(dbg_rvalid), .dbg_rdata(dbg_rdata),
    .CEN(cen), .WEN(wen), .OEN(oen), .A(a), .Data2Mem(d2m), .ReadDataMem(rdm)
  );

  dmem_arbiter #(.AW(AW), .DW(DW), .ARB_MODE(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n),
    .core_req(core_req), .core_we(core_we), .core_addr(core_addr), .core_wdata(core_wdata),
    .core_gnt(core_gnt1), .core_rvalid(core_rvalid1), .core_rdata(core_rdata1),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
    .dbg_gnt(dbg_gnt1), .dbg_rvalid(dbg_rvalid1), .dbg_rdata(dbg_rdata1),
    .CEN(cen1), .WEN(wen1), .OEN(oen1), .A(a1), .Data2Mem(d2m1), .ReadDataMem(rdm1)
  );

  typedef struct {
    logic cr, dr;
    logic ecg, edg, ecg1, edg1;
  } gvec_t;

  typedef struct {
    int          due;
    bit          port;
    logic [31:0] data;
  } rd_t;

  gvec_t gv [4];
  rd_t   rq [$];

  int cont_a  [7] = '{0, 1, 2, 1, 2, 2, 0};
  int gap_a   [7] = '{0, 10, 10, 11, 12, 12, 12};
  int gap_cen [7] = '{1, 0, 1, 0, 0, 1, 1};
  int gap_rv  [7] = '{0, 0, 1, 0, 1, 1, 0};

  task automatic chk1(input string name, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b expected %b at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic chkw(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drv_core(input logic r, input logic w, input logic [AW-1:0] ad, input logic [DW-1:0] wd);
    core_req = r; core_we = w; core_addr = ad; core_wdata = wd;
  endtask

  task automatic drv_dbg(input logic r, input logic w, input logic [AW-1:0] ad, input logic [DW-1:0] wd);
    dbg_req = r; dbg_we = w; dbg_addr = ad; dbg_wdata = wd;
  endtask

  task automatic do_reset();
    drv_core(0, 0, '0, '0);
    drv_dbg(0, 0, '0, '0);
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    logic        lg_m, pc, pd, cr, cw, dr, dw, cg, dg;
    logic        ecen, ewen, eoen, ecv, edv;
    logic [AW-1:0] ca, da, ea;
    logic [DW-1:0] cd, dd, ed, exp_rd;
    logic [DW-1:0] ref_mem [128];
    int cyc;

    gv[0] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    gv[1] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    gv[2] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    gv[3] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};

    drv_core(0, 0, '0, '0);
    drv_dbg(0, 0, '0, '0);
    #2 rst_n = 1'b0;
    tick();
    tick();
    mem_clr = 1'b0;

    // Grant is combinational and live while reset is held; lg resets to dbg.
    for (int i = 0; i < 4; i++) begin
      core_req = gv[i].cr;
      dbg_req  = gv[i].dr;
      #1;
      chk1("rst_core_gnt", core_gnt, gv[i].ecg);
      chk1("rst_dbg_gnt", dbg_gnt, gv[i].edg);
      chk1("rst_core_gnt_fixed", core_gnt1, gv[i].ecg1);
      chk1("rst_dbg_gnt_fixed", dbg_gnt1, gv[i].edg1);
      chk1("rst_cen", cen, 1'b1);
    end
    drv_core(0, 0, '0, '0);
    drv_dbg(0, 0, '0, '0);
    tick();
    rst_n = 1'b1;

    // Core write then read of the same word.
    drv_core(1, 1, 7'h05, 32'hDEADBEEF);
    #1 chk1("wr_gnt", core_gnt, 1'b1);
    tick();
    drv_core(1, 0, 7'h05, '0);
    #1;
    chk1("rd_gnt", core_gnt, 1'b1);
    chk1("wr_cen", cen, 1'b0);
    chk1("wr_wen", wen, 1'b0);
    chk1("wr_oen", oen, 1'b1);
    chkw("wr_a", 32'(a), 32'h5);
    chkw("wr_d2m", d2m, 32'hDEADBEEF);
    tick();
    drv_core(0, 0, '0, '0);
    #1;
    chk1("rd_cen", cen, 1'b0);
    chk1("rd_wen", wen, 1'b1);
    chk1("rd_oen", oen, 1'b0);
    chkw("rd_a", 32'(a), 32'h5);
    chk1("rd_early_rvalid", core_rvalid, 1'b0);
    tick();
    chk1("rd_rvalid", core_rvalid, 1'b1);
    chkw("rd_rdata", core_rdata, 32'hDEADBEEF);
    chk1("rd_dbg_rvalid", dbg_rvalid, 1'b0);
    chk1("rd_idle_cen", cen, 1'b1);
    tick();
    chk1("rd_rvalid_once", core_rvalid, 1'b0);

    // Asynchronous reset asserted mid-cycle with a command and an rvalid live.
    drv_core(1, 0, 7'h05, '0);
    tick();
    drv_core(1, 1, 7'h03, 32'h00001234);
    tick();
    drv_core(0, 0, '0, '0);
    #1 chk1("pre_rst_rvalid", core_rvalid, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk1("arst_cen", cen, 1'b1);
    chk1("arst_wen", wen, 1'b1);
    chk1("arst_oen", oen, 1'b1);
    chkw("arst_a", 32'(a), 32'h0);
    chkw("arst_d2m", d2m, 32'h0);
    chk1("arst_core_rvalid", core_rvalid, 1'b0);
    chk1("arst_dbg_rvalid", dbg_rvalid, 1'b0);
    tick();
    rst_n = 1'b1;

    // Debug read in flight when reset pulses: its rvalid must never appear.
    drv_dbg(1, 0, 7'h04, '0);
    #1 chk1("inf_gnt", dbg_gnt, 1'b1);
    tick();
    drv_dbg(0, 0, '0, '0);
    #1 chk1("inf_cmd_oen", oen, 1'b0);
    #2 rst_n = 1'b0;
    tick();
    chk1("inf_rvalid_rst", dbg_rvalid, 1'b0);
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk1("inf_rvalid_after", dbg_rvalid, 1'b0);
      chk1("inf_cen_idle", cen, 1'b1);
    end
    drv_core(1, 1, 7'h09, 32'hCAFE0009);
    tick();
    drv_core(0, 0, '0, '0);
    #1;
    chk1("inf_new_cen", cen, 1'b0);
    chkw("inf_new_a", 32'(a), 32'h9);

    // Preload words 10..12 from the debug port, then core reads with idle gaps.
    for (int i = 0; i < 3; i++) begin
      drv_dbg(1, 1, 7'(10 + i), 32'hA0000010 + 32'(i));
      tick();
    end
    drv_dbg(0, 0, '0, '0);
    tick();
    tick();
    for (int c = 0; c < 7; c++) begin
      case (c)
        0: drv_core(1, 0, 7'd10, '0);
        2: drv_core(1, 0, 7'd11, '0);
        3: drv_core(1, 0, 7'd12, '0);
        default: drv_core(0, 0, '0, '0);
      endcase
      #1;
      chk1("gap_rvalid", core_rvalid, gap_rv[c] != 0);
      chk1("gap_cen", cen, gap_cen[c] != 0);
      if (c > 0) chkw("gap_a", 32'(a), 32'(gap_a[c]));
      if (c == 2) chkw("gap_rdata0", core_rdata, 32'hA0000010);
      if (c == 4) chkw("gap_rdata1", core_rdata, 32'hA0000011);
      if (c == 5) chkw("gap_rdata2", core_rdata, 32'hA0000012);
      tick();
    end

    // Contention from reset: round-robin alternates, fixed priority starves dbg.
    do_reset();
    for (int c = 0; c < 7; c++) begin
      if (c < 4) begin
        drv_core(1, 0, 7'd1, '0);
        drv_dbg(1, 0, 7'd2, '0);
      end else if (c == 4) begin
        drv_core(0, 0, '0, '0);
        drv_dbg(1, 0, 7'd2, '0);
      end else begin
        drv_core(0, 0, '0, '0);
        drv_dbg(0, 0, '0, '0);
      end
      #1;
      if (c < 4) begin
        chk1("rr_core_gnt", core_gnt, (c % 2) == 0);
        chk1("rr_dbg_gnt", dbg_gnt, (c % 2) == 1);
      end
      if (c <= 4) begin
        chk1("fp_core_gnt", core_gnt1, c < 4);
        chk1("fp_dbg_gnt", dbg_gnt1, c == 4);
      end
      if (c >= 1 && c <= 5) chkw("rr_a", 32'(a), 32'(cont_a[c]));
      chk1("rr_core_rvalid", core_rvalid, c == 2 || c == 4);
      chk1("rr_dbg_rvalid", dbg_rvalid, c == 3 || c == 5 || c == 6);
      tick();
    end

    // Random traffic against a grant-rule / memory-order reference model.
    mem_clr = 1'b1;
    do_reset();
    mem_clr = 1'b0;
    for (int i = 0; i < 128; i++) ref_mem[i] = '0;
    lg_m = 1'b1;
    pc = 1'b0; pd = 1'b0;
    ecen = 1'b1; ewen = 1'b1; eoen = 1'b1; ea = '0; ed = '0;
    cr = 0; cw = 0; ca = '0; cd = '0; dr = 0; dw = 0; da = '0; dd = '0;
    rq.delete();
    for (cyc = 0; cyc < 400; cyc++) begin
      if (!pc) begin
        cr = ($urandom_range(0, 9) < 6);
        cw = $urandom_range(0, 1) == 1;
        ca = 7'($urandom_range(0, 15));
        cd = $urandom;
      end
      if (!pd) begin
        dr = ($urandom_range(0, 9) < 6);
        dw = $urandom_range(0, 1) == 1;
        da = 7'($urandom_range(0, 15));
        dd = $urandom;
      end
      drv_core(cr, cw, ca, cd);
      drv_dbg(dr, dw, da, dd);
      #1;
      cg = cr && (!dr || lg_m);
      dg = dr && !cg;
      chk1("rnd_core_gnt", core_gnt, cg);
      chk1("rnd_dbg_gnt", dbg_gnt, dg);
      chk1("rnd_core_gnt_fixed", core_gnt1, cr);
      chk1("rnd_dbg_gnt_fixed", dbg_gnt1, dr && !cr);
      chk1("rnd_cen", cen, ecen);
      chk1("rnd_wen", wen, ewen);
      chk1("rnd_oen", oen, eoen);
      chkw("rnd_a", 32'(a), 32'(ea));
      chkw("rnd_d2m", d2m, ed);
      ecv = 1'b0; edv = 1'b0; exp_rd = '0;
      if (rq.size() > 0 && rq[0].due == cyc) begin
        ecv = (rq[0].port == 1'b0);
        edv = (rq[0].port == 1'b1);
        exp_rd = rq[0].data;
        void'(rq.pop_front());
        chkw("rnd_rdata", ecv ? core_rdata : dbg_rdata, exp_rd);
      end
      chk1("rnd_core_rvalid", core_rvalid, ecv);
      chk1("rnd_dbg_rvalid", dbg_rvalid, edv);
      if (cg || dg) begin
        lg_m = dg;
        ecen = 1'b0;
        ea   = cg ? ca : da;
        ed   = cg ? cd : dd;
        ewen = cg ? !cw : !dw;
        eoen = cg ? cw : dw;
        if (!ewen) ref_mem[ea] = ed;
        else rq.push_back('{cyc + 2, dg, ref_mem[ea]});
      end else begin
        ecen = 1'b1; ewen = 1'b1; eoen = 1'b1;
      end
      pc = cr && !cg;
      pd = dr && !dg;
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-port arbiter and sequencer for the single-port data SRAM used by the single-cycle MIPS core. It shares the memory between the core's load/store path and a debug/loader port that preloads or inspects data memory. It converts active-high request/grant handshakes into the SRAM's registered, active-low CEN/WEN/OEN/A/Data2Mem controls, and returns read data to the requester that issued each read. Accepted accesses are pipelined, with at most one memory command per cycle.

## Interface
- AW, 7: memory word-address width (drives A).
- DW, 32: data width.
- ARB_MODE, 0: 0 = round-robin between ports; 1 = fixed priority, core always wins.
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- core_req  in  1  core access request.
- core_we  in  1  1 = write, 0 = read.
- core_addr  in  AW  word address.
- core_wdata  in  DW  write data.
- core_gnt  out  1  request accepted this cycle (combinational).
- core_rvalid  out  1  read data valid on core_rdata.
- core_rdata  out  DW  read data.
- dbg_req, dbg_we, dbg_addr, dbg_wdata, dbg_gnt, dbg_rvalid, dbg_rdata: same as the core_* ports, for the debug/loader requester.
- CEN  out  1  SRAM chip enable, active-low, registered.
- WEN  out  1  SRAM write enable, active-low, registered.
- OEN  out  1  SRAM output enable, active-low, registered.
- A  out  AW  SRAM address, registered.
- Data2Mem  out  DW  SRAM write data, registered.
- ReadDataMem  in  DW  SRAM read data; valid in the cycle after the SRAM samples a read command.

## Operation
- **Requester rules.** A requester holds req, we, addr and wdata stable until it sees gnt high. The access is accepted at the rising edge that ends a cycle with gnt=1.
- **Grant logic.** gnt is combinational from the req inputs and the priority pointer. At most one of core_gnt/dbg_gnt is high in any cycle.
  - Only one port requesting: that port is granted.
  - Both requesting, ARB_MODE=0: grant the port not indicated by the last-grant pointer `lg`.
  - Both requesting, ARB_MODE=1: grant core.
- **Last-grant pointer.** `lg` updates to the granted port on every grant. Reset value = dbg, so core wins the first contention.
- **Command stage.** On an accepted access, the next edge loads:
  - CEN=0; A=addr; Data2Mem=wdata.
  - Write: WEN=0, OEN=1.
  - Read: WEN=1, OEN=0.
- **Idle.** With no grant, the next edge loads CEN=1, WEN=1, OEN=1. A and Data2Mem hold their previous values.
- **Read tag pipeline.** A 2-entry shift pipeline of {valid, port} follows each read. The stage-2 entry selects which rvalid fires.
  - Both rdata outputs are wired to ReadDataMem.
  - A port's rdata is meaningful only while its rvalid=1.
- **Writes** produce no rvalid.
- **Ordering.** Memory order equals grant order. A read granted after a write to the same address returns the new data; no forwarding is required, because the SRAM serializes.

## Timing
- **Reset values** (asynchronous, immediate on rst_n=0):
  - CEN=1, WEN=1, OEN=1, A=0, Data2Mem=0.
  - core_rvalid=0, dbg_rvalid=0.
  - Tag pipeline empty; lg=dbg.
- **Gnt during reset.** core_gnt/dbg_gnt follow the combinational rules even while rst_n=0, but no acceptance occurs until the first edge after reset release.
- **Latency.** Request granted in cycle N:
  - Command on the SRAM pins in cycle N+1.
  - Read: rvalid=1 with data in cycle N+2 for exactly one cycle.
- **Throughput.** One access per cycle sustained. Back-to-back reads from alternating ports return in grant order on consecutive cycles.
- **Stall.** A requester that sees req=1 with gnt=0 stalls. Under round-robin, the wait is at most 1 cycle when both ports request continuously.
- **Simultaneous events.**
  - A new grant and an rvalid to the same port may occur in the same cycle.
  - A new command and the read-data return overlap legally, since the pipeline is decoupled.
- **Reset mid-operation.** In-flight reads are discarded, and no rvalid is issued for them after reset release. The SRAM sees CEN=1 from the reset edge onward.
- **Address width.** addr is used directly as the AW-bit word address, with no wrap logic. Upper address bits are the requester's responsibility.

## Test plan
- **Reset check:** assert rst_n=0 mid-cycle -> CEN/WEN/OEN=1, A=0, Data2Mem=0, and both rvalid=0 immediately, without waiting for a clock edge.
- **Core write then read:** core write addr=7'h05, wdata=32'hDEADBEEF, then read addr=7'h05 on the next cycle:
  - cycle N+1: CEN=0, WEN=0, A=5, Data2Mem=DEADBEEF.
  - cycle N+3: core_rvalid=1, core_rdata=DEADBEEF.
- **Contention, ARB_MODE=0:** both ports issue continuous reads (core addr 1, dbg addr 2) starting right after reset -> grant sequence core, dbg, core, dbg; A sequence 1,2,1,2; rvalid alternates core/dbg two cycles after each grant.
- **Contention, ARB_MODE=1:** both ports request for 4 cycles -> core_gnt=1 every cycle and dbg_gnt=0 until core_req drops; dbg is granted in the first cycle with core_req=0.
- **Reset during outstanding reads:** dbg read granted at cycle N, rst_n pulsed low during cycle N+1 -> no dbg_rvalid at N+2 or later; first command after release is driven only by a new grant.
- **Single-port idle gaps:** core reads at cycles 0, 2, 3 (addr 10, 11, 12) -> core_rvalid at cycles 2, 4, 5; CEN=1 in cycles 2 and 5+; A holds 10 through idle cycle 2.
